coin_input_encoder: RTL and testbench

- Upstream front end of the vending-machine FSM (vend_test).
- Converts two raw, bouncy coin-sensor levels (half-unit slot, one-unit slot) into clean single-cycle 2-bit coin codes on D_out, which drives the FSM's D_in.
- Each code pulse is followed by at least one idle (00) cycle.
- Coins arriving in bursts are queued in a small FIFO so none are lost until it is full.

---
 rtl/vend_pkg.sv | 15 +
 rtl/coin_debounce.sv | 44 ++++
 rtl/coin_input_encoder.sv | 150 +++++++++++++++
 tb/tb_coin_input_encoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared coin codes and output-FSM states for the vending-machine front end.
package vend_pkg;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_HALF = 2'b01;
    localparam logic [1:0] CODE_ONE  = 2'b10;
    localparam logic [1:0] CODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } out_state_t;

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor channel: 2-flop synchronizer, stability counter and a
// single-cycle pulse on the edge where the debounced level rises.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_meta;
    logic             sync_q;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // The level flips on the same edge the counter would reach its limit.
    assign flip = (sync_q != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign rise = flip && sync_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            level     <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= raw;
            sync_q    <= sync_meta;
            if (sync_q == level) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= sync_q;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coin_input_encoder.sv
// Turns two bouncy coin sensors into queued, spaced single-cycle coin codes
// for the vending FSM.
module coin_input_encoder
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Coin_half_raw,
    input  logic       Coin_one_raw,
    output logic [1:0] D_out,
    output logic       Overflow,
    output logic       Fifo_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    logic             rise_half;
    logic             rise_one;
    logic             pend_half;
    logic             pend_one;
    logic             pend_half_nxt;
    logic             pend_one_nxt;
    logic             push_valid;
    logic [1:0]       push_code;
    logic [1:0]       mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             accept;
    out_state_t       state;
    logic [GAP_W-1:0] gap_cnt;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_half (
        .Clk   (Clk),
        .Reset (Reset),
        .raw   (Coin_half_raw),
        .rise  (rise_half)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_one (
        .Clk   (Clk),
        .Reset (Reset),
        .raw   (Coin_one_raw),
        .rise  (rise_one)
    );

    // One push per cycle; deferred coins always go ahead of fresh rises so
    // arrival order is kept and nothing is merged.
    always_comb begin
        push_valid    = 1'b0;
        push_code     = CODE_NONE;
        pend_half_nxt = pend_half;
        pend_one_nxt  = pend_one;
        if (pend_one) begin
            push_valid    = 1'b1;
            push_code     = CODE_ONE;
            pend_one_nxt  = rise_one;
            pend_half_nxt = pend_half | rise_half;
        end else if (pend_half) begin
            push_valid    = 1'b1;
            push_code     = CODE_HALF;
            pend_half_nxt = rise_half;
            pend_one_nxt  = rise_one;
        end else if (rise_half) begin
            push_valid    = 1'b1;
            push_code     = CODE_HALF;
            pend_one_nxt  = rise_one;
        end else if (rise_one) begin
            push_valid    = 1'b1;
            push_code     = CODE_ONE;
        end
    end

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = (state == IDLE) && !empty;
    assign accept     = push_valid && (!full || pop);
    assign Fifo_empty = empty;

    always_ff @(posedge Clk) begin
        if (accept) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_code;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr    <= '0;
            pend_half <= 1'b0;
            pend_one  <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            pend_half <= pend_half_nxt;
            pend_one  <= pend_one_nxt;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end else if (push_valid) begin
                Overflow <= 1'b1;
            end
        end
    end

    // The head code is registered straight onto D_out on the popping edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            D_out   <= CODE_NONE;
            rd_ptr  <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        D_out  <= mem[rd_ptr[PTR_W-1:0]];
                        rd_ptr <= rd_ptr + 1'b1;
                        state  <= EMIT;
                    end else begin
                        D_out <= CODE_NONE;
                    end
                end
                EMIT: begin
                    D_out   <= CODE_NONE;
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    D_out <= CODE_NONE;
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    D_out <= CODE_NONE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_input_encoder.sv
// Bench for coin_input_encoder: directed timing scenarios plus random coin
// traffic compared against an ordered list of expected coins.
module tb_coin_input_encoder;
    import vend_pkg::*;

    localparam int SLOW_GAP = 60;

    logic       Clk;
    logic       Reset;
    logic       Coin_half_raw;
    logic       Coin_one_raw;
    logic [1:0] d_fast;
    logic [1:0] d_slow;
    logic       ovf_fast;
    logic       ovf_slow;
    logic       empty_fast;
    logic       empty_slow;

    int         n_checks;
    int         n_fails;
    logic [1:0] log_fast [$];
    logic [1:0] log_slow [$];
    logic [1:0] exp_q [$];
    logic [1:0] prev_fast;
    logic [1:0] prev_slow;
    int         rem [2];
    logic       lvl [2];

    coin_input_encoder #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4), .GAP_CYCLES(1)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Coin_half_raw (Coin_half_raw),
        .Coin_one_raw  (Coin_one_raw),
        .D_out         (d_fast),
        .Overflow      (ovf_fast),
        .Fifo_empty    (empty_fast)
    );

    // A long gap throttles draining so bursts can fill the queue.
    coin_input_encoder #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4), .GAP_CYCLES(SLOW_GAP)) dut_slow (
        .Clk           (Clk),
        .Reset         (Reset),
        .Coin_half_raw (Coin_half_raw),
        .Coin_one_raw  (Coin_one_raw),
        .D_out         (d_slow),
        .Overflow      (ovf_slow),
        .Fifo_empty    (empty_slow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic half, input logic one);
        Coin_half_raw = half;
        Coin_one_raw  = one;
        @(posedge Clk);
        #1;
    endtask

    task automatic resetDut();
        Coin_half_raw = 1'b0;
        Coin_one_raw  = 1'b0;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        log_fast.delete();
        log_slow.delete();
    endtask

    always @(negedge Clk) begin
        if (d_fast != CODE_NONE) begin
            checkOutput("fast_idle_between", prev_fast, CODE_NONE);
            checkOutput("fast_not_rsvd", d_fast == CODE_RSVD, 0);
            log_fast.push_back(d_fast);
        end
        if (d_slow != CODE_NONE) begin
            checkOutput("slow_idle_between", prev_slow, CODE_NONE);
            checkOutput("slow_not_rsvd", d_slow == CODE_RSVD, 0);
            log_slow.push_back(d_slow);
        end
        prev_fast = d_fast;
        prev_slow = d_slow;
    end

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        prev_fast     = CODE_NONE;
        prev_slow     = CODE_NONE;
        Coin_half_raw = 1'b0;
        Coin_one_raw  = 1'b0;
        Reset         = 1'b0;
        #1 Reset = 1'b1;
        #1;
        checkOutput("rst_dout", d_fast, CODE_NONE);
        checkOutput("rst_empty", empty_fast, 1);
        checkOutput("rst_overflow", ovf_fast, 0);
        resetDut();

        $display("[TB] clean half coin");
        for (int c = 0; c < 14; c++) begin
            applyStimulus(c < 10, 1'b0);
            checkOutput("clean_half_timing", d_fast, (c == 6) ? CODE_HALF : CODE_NONE);
        end
        repeat (10) applyStimulus(1'b0, 1'b0);
        checkOutput("clean_half_count", log_fast.size(), 1);

        $display("[TB] bounce and glitch");
        resetDut();
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1'b0, (c < 9) ? (c % 3 != 2) : (c < 17));
        end
        checkOutput("bounce_count", log_fast.size(), 1);
        if (log_fast.size() > 0) checkOutput("bounce_code", log_fast[0], CODE_ONE);
        log_fast.delete();
        for (int c = 0; c < 15; c++) applyStimulus(1'b0, c < 3);
        checkOutput("glitch_none", log_fast.size(), 0);

        $display("[TB] simultaneous rises");
        resetDut();
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("simul_seq", d_fast,
                        (c == 6) ? CODE_HALF : ((c == 9) ? CODE_ONE : CODE_NONE));
        end
        repeat (12) applyStimulus(1'b0, 1'b0);
        checkOutput("simul_count", log_fast.size(), 2);

        $display("[TB] burst overflow");
        resetDut();
        for (int c = 0; c < 80; c++) begin
            applyStimulus((c < 6) || (c >= 14 && c < 20) || (c >= 26 && c < 32) || (c >= 38 && c < 44),
                          (c >= 14 && c < 20) || (c >= 26 && c < 32) || (c >= 38 && c < 44));
        end
        checkOutput("burst_overflow_set", ovf_slow, 1);
        repeat (4 * (SLOW_GAP + 2)) applyStimulus(1'b0, 1'b0);
        checkOutput("burst_overflow_sticky", ovf_slow, 1);
        checkOutput("burst_count", log_slow.size(), 5);
        exp_q = {CODE_HALF, CODE_HALF, CODE_ONE, CODE_HALF, CODE_ONE};
        for (int i = 0; i < 5 && i < log_slow.size(); i++) checkOutput("burst_order", log_slow[i], exp_q[i]);
        checkOutput("burst_drained", empty_slow, 1);

        $display("[TB] full queue with pop and push on one edge");
        resetDut();
        for (int c = 0; c < 80; c++) begin
            applyStimulus((c < 6) || (c >= 12 && c < 18) || (c >= 24 && c < 30) ||
                          (c >= SLOW_GAP + 3 && c < SLOW_GAP + 10),
                          (c >= 12 && c < 18) || (c >= 24 && c < 30));
        end
        checkOutput("fullpop_no_overflow", ovf_slow, 0);
        repeat (5 * (SLOW_GAP + 2)) applyStimulus(1'b0, 1'b0);
        checkOutput("fullpop_count", log_slow.size(), 6);
        exp_q = {CODE_HALF, CODE_HALF, CODE_ONE, CODE_HALF, CODE_ONE, CODE_HALF};
        for (int i = 0; i < 6 && i < log_slow.size(); i++) checkOutput("fullpop_order", log_slow[i], exp_q[i]);
        checkOutput("fullpop_overflow_final", ovf_slow, 0);

        $display("[TB] reset mid-operation");
        resetDut();
        for (int c = 0; c <= SLOW_GAP + 8; c++) begin
            applyStimulus((c >= 12 && c < 18) || (c >= 24 && c < 30),
                          (c < 6) || (c >= 12 && c < 18));
        end
        checkOutput("midrst_pre_dout", d_slow, CODE_HALF);
        checkOutput("midrst_pre_empty", empty_slow, 0);
        Reset = 1'b1;
        #1;
        checkOutput("midrst_dout", d_slow, CODE_NONE);
        checkOutput("midrst_empty", empty_slow, 1);
        checkOutput("midrst_overflow", ovf_slow, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        log_slow.delete();
        repeat (3 * (SLOW_GAP + 2)) applyStimulus(1'b0, 1'b0);
        checkOutput("midrst_nothing_after", log_slow.size(), 0);

        $display("[TB] random coin traffic");
        resetDut();
        exp_q.delete();
        for (int ch = 0; ch < 2; ch++) begin
            lvl[ch] = 1'b0;
            rem[ch] = int'($urandom_range(6, 12));
        end
        for (int c = 0; c < 1500; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (rem[ch] == 0) begin
                    if (lvl[ch] == 1'b0) begin
                        lvl[ch] = 1'b1;
                        if ($urandom_range(0, 2) == 0) begin
                            rem[ch] = int'($urandom_range(1, 3));
                        end else begin
                            rem[ch] = int'($urandom_range(6, 12));
                            exp_q.push_back((ch == 0) ? CODE_HALF : CODE_ONE);
                        end
                    end else begin
                        lvl[ch] = 1'b0;
                        rem[ch] = int'($urandom_range(6, 12));
                    end
                end
                rem[ch]--;
            end
            applyStimulus(lvl[0], lvl[1]);
        end
        repeat (40) applyStimulus(1'b0, 1'b0);
        checkOutput("rand_count", log_fast.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_fast.size(); i++) begin
            checkOutput("rand_code", log_fast[i], exp_q[i]);
        end
        checkOutput("rand_no_overflow", ovf_fast, 0);
        checkOutput("rand_drained", empty_fast, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
